dumbrv_lsu: RTL and testbench

Load/store unit sitting directly behind the ALU stage. It accepts the ALU output bundle (op, val1 = effective address, val2, val3 = store data) with a valid/ready handshake. Memory ops are performed as byte-serial transfers on a narrow req/ack memory bus; all other ops pass straight through. A writeback result is presented to the register-file stage with its own valid/ready handshake.

---
 rtl/dumbrv_lsu.sv | 153 +++++++++++++++
 tb/tb_dumbrv_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dumbrv_lsu.sv
// Load/store unit behind the ALU stage: byte-serial memory transfers on a
// req/ack bus, pass-through for non-memory ops, valid/ready writeback port.
module dumbrv_lsu #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [5:0]        op_i,
   input  logic [31:0]       val1_i,
   input  logic [31:0]       val3_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   input  logic              mem_ack_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic              out_wb_o,
   output logic [31:0]       result_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_RESP
   } state_e;

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic              sign_q, sign_d;
   logic [1:0]        last_q, last_d;   // byte count minus one
   logic [1:0]        idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       sdata_q, sdata_d;
   logic [31:0]       result_q, result_d;
   logic              wb_q, wb_d;

   logic [31:0]       merged;
   logic [31:0]       extended;
   logic              xfer;
   logic              resp;

   assign xfer = (state_q == S_XFER);
   assign resp = (state_q == S_RESP);

   // Bus and writeback outputs are gated by state so that an asynchronous
   // reset drops them in the same instant the state register clears.
   assign in_ready_o  = (state_q == S_IDLE);
   assign mem_req_o   = xfer;
   assign mem_we_o    = xfer & wr_q;
   assign mem_addr_o  = xfer ? (addr_q + ADDR_W'(idx_q)) : '0;
   assign mem_wdata_o = xfer ? sdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
   assign out_valid_o = resp;
   assign out_wb_o    = resp & wb_q;
   assign result_o    = resp ? result_q : 32'h0;

   // NOTE: every variable written in an always_comb gets a default first,
   // otherwise paths that skip an assignment infer a latch.
   always_comb begin
      merged                          = result_q;
      merged[{idx_q, 3'b000} +: 8]    = mem_rdata_i;
      case (last_q)
         2'd0:    extended = {{24{sign_q & merged[7]}},  merged[7:0]};
         2'd1:    extended = {{16{sign_q & merged[15]}}, merged[15:0]};
         default: extended = merged;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      sign_d   = sign_q;
      last_d   = last_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      sdata_d  = sdata_q;
      result_d = result_q;
      wb_d     = wb_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               if (!op_i[5]) begin
                  result_d = val1_i;
                  wb_d     = 1'b1;
                  state_d  = S_RESP;
               end else begin
                  wr_d     = op_i[3];
                  sign_d   = op_i[2];
                  last_d   = op_i[0] ? 2'd0 : (op_i[1] ? 2'd1 : 2'd3);
                  addr_d   = val1_i[ADDR_W-1:0];
                  sdata_d  = val3_i;
                  result_d = 32'h0;
                  wb_d     = ~op_i[3];
                  idx_d    = 2'd0;
                  state_d  = S_XFER;
               end
            end
         end
         S_XFER: begin
            if (mem_ack_i) begin
               if (!wr_q) begin
                  result_d = merged;
               end
               if (idx_q == last_q) begin
                  if (!wr_q) begin
                     result_d = extended;
                  end
                  state_d = S_RESP;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         S_RESP: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its peers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         sign_q   <= 1'b0;
         last_q   <= 2'd0;
         idx_q    <= 2'd0;
         addr_q   <= '0;
         sdata_q  <= 32'h0;
         result_q <= 32'h0;
         wb_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         sign_q   <= sign_d;
         last_q   <= last_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         sdata_q  <= sdata_d;
         result_q <= result_d;
         wb_q     <= wb_d;
      end
   end

endmodule

// File: tb/tb_dumbrv_lsu.sv
// Directed bench for dumbrv_lsu: inputs driven and outputs sampled on the
// falling edge, acting as both the ALU source and the byte-wide memory.
module tb_dumbrv_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [5:0]  op_i = 6'h00;
   logic [31:0] val1_i = 32'h0;
   logic [31:0] val3_i = 32'h0;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [15:0] mem_addr_o;
   logic [7:0]  mem_wdata_o;
   logic [7:0]  mem_rdata_i = 8'h00;
   logic        mem_ack_i = 1'b0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic        out_wb_o;
   logic [31:0] result_o;

   int compared = 0;
   int mismatched = 0;
   logic req_seen = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_req_o) req_seen <= 1'b1;

   dumbrv_lsu #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .op_i(op_i), .val1_i(val1_i), .val3_i(val3_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_wb_o(out_wb_o), .result_o(result_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".in_ready"},  32'(in_ready_o),  32'h1);
      check({tag, ".req"},       32'(mem_req_o),   32'h0);
      check({tag, ".we"},        32'(mem_we_o),    32'h0);
      check({tag, ".addr"},      32'(mem_addr_o),  32'h0);
      check({tag, ".wdata"},     32'(mem_wdata_o), 32'h0);
      check({tag, ".out_valid"}, 32'(out_valid_o), 32'h0);
      check({tag, ".wb"},        32'(out_wb_o),    32'h0);
      check({tag, ".result"},    result_o,         32'h0);
   endtask

   // Present one bundle for a single cycle; returns in the cycle after accept.
   task automatic send(input string tag, input logic [5:0] op, input logic [31:0] v1,
                       input logic [31:0] v3);
      check({tag, ".in_ready"}, 32'(in_ready_o), 32'h1);
      in_valid_i = 1'b1;
      op_i       = op;
      val1_i     = v1;
      val3_i     = v3;
      @(negedge clk);
      in_valid_i = 1'b0;
      val1_i     = 32'h0;
      val3_i     = 32'h0;
   endtask

   // Serve one byte: hold ack low for 'waits' cycles checking bus stability,
   // then ack with 'rdata'.
   task automatic bus_byte(input string tag, input logic [15:0] addr, input logic we,
                           input logic [7:0] wdata, input logic [7:0] rdata, input int waits);
      for (int w = 0; w <= waits; w++) begin
         check({tag, ".req"},  32'(mem_req_o),  32'h1);
         check({tag, ".addr"}, 32'(mem_addr_o), 32'(addr));
         check({tag, ".we"},   32'(mem_we_o),   32'(we));
         if (we) check({tag, ".wdata"}, 32'(mem_wdata_o), 32'(wdata));
         check({tag, ".in_ready"}, 32'(in_ready_o), 32'h0);
         if (w == waits) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rdata;
         end
         @(negedge clk);
      end
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'h00;
   endtask

   // Expect RESP now, retire it, and expect IDLE on the following cycle.
   task automatic retire(input string tag, input logic [31:0] res, input logic wb);
      check({tag, ".out_valid"}, 32'(out_valid_o), 32'h1);
      check({tag, ".result"},    result_o,         res);
      check({tag, ".wb"},        32'(out_wb_o),    32'(wb));
      check({tag, ".req_off"},   32'(mem_req_o),   32'h0);
      out_ready_i = 1'b1;
      @(negedge clk);
      out_ready_i = 1'b0;
      check({tag, ".back_idle"}, 32'(in_ready_o),  32'h1);
      check({tag, ".valid_off"}, 32'(out_valid_o), 32'h0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_reset");

      // Pass-through
      req_seen = 1'b0;
      send("pass", 6'h00, 32'hDEADBEEF, 32'h0);
      retire("pass", 32'hDEADBEEF, 1'b1);
      check("pass.no_req", 32'(req_seen), 32'h0);

      // LB signed, LBU, b-wins-over-h
      send("lb", 6'h25, 32'h0000_0010, 32'h0);
      bus_byte("lb.b0", 16'h0010, 1'b0, 8'h00, 8'h80, 0);
      retire("lb", 32'hFFFFFF80, 1'b1);
      send("lbu", 6'h21, 32'h0000_0010, 32'h0);
      bus_byte("lbu.b0", 16'h0010, 1'b0, 8'h00, 8'h80, 0);
      retire("lbu", 32'h00000080, 1'b1);
      send("op23", 6'h23, 32'h0000_0010, 32'h0);
      bus_byte("op23.b0", 16'h0010, 1'b0, 8'h00, 8'h80, 0);
      retire("op23", 32'h00000080, 1'b1);

      // LHU across address wrap, LH signed
      send("lhu", 6'h22, 32'h0000_FFFF, 32'h0);
      bus_byte("lhu.b0", 16'hFFFF, 1'b0, 8'h00, 8'h34, 0);
      bus_byte("lhu.b1", 16'h0000, 1'b0, 8'h00, 8'h12, 0);
      retire("lhu", 32'h00001234, 1'b1);
      send("lh", 6'h26, 32'h0000_0200, 32'h0);
      bus_byte("lh.b0", 16'h0200, 1'b0, 8'h00, 8'hCD, 0);
      bus_byte("lh.b1", 16'h0201, 1'b0, 8'h00, 8'hAB, 0);
      retire("lh", 32'hFFFFABCD, 1'b1);

      // SW with 0..3 wait states per byte
      send("sw", 6'h28, 32'h0000_0100, 32'h11223344);
      bus_byte("sw.b0", 16'h0100, 1'b1, 8'h44, 8'h00, 0);
      bus_byte("sw.b1", 16'h0101, 1'b1, 8'h33, 8'h00, 1);
      bus_byte("sw.b2", 16'h0102, 1'b1, 8'h22, 8'h00, 2);
      bus_byte("sw.b3", 16'h0103, 1'b1, 8'h11, 8'h00, 3);
      retire("sw", 32'h00000000, 1'b0);

      // LW with writeback backpressure
      send("lw", 6'h20, 32'h0000_0300, 32'h0);
      bus_byte("lw.b0", 16'h0300, 1'b0, 8'h00, 8'h78, 0);
      bus_byte("lw.b1", 16'h0301, 1'b0, 8'h00, 8'h56, 0);
      bus_byte("lw.b2", 16'h0302, 1'b0, 8'h00, 8'h34, 0);
      bus_byte("lw.b3", 16'h0303, 1'b0, 8'h00, 8'h12, 0);
      for (int i = 0; i < 5; i++) begin
         check("lw.hold.valid",    32'(out_valid_o), 32'h1);
         check("lw.hold.result",   result_o,         32'h12345678);
         check("lw.hold.in_ready", 32'(in_ready_o),  32'h0);
         @(negedge clk);
      end
      retire("lw", 32'h12345678, 1'b1);

      // Spurious ack while idle
      mem_ack_i   = 1'b1;
      mem_rdata_i = 8'hFF;
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = 8'h00;
      check("spur.req",      32'(mem_req_o),   32'h0);
      check("spur.valid",    32'(out_valid_o), 32'h0);
      check("spur.in_ready", 32'(in_ready_o),  32'h1);

      // Reset after second byte of an LW
      send("rst_lw", 6'h20, 32'h0000_0400, 32'h0);
      bus_byte("rst_lw.b0", 16'h0400, 1'b0, 8'h00, 8'hAA, 0);
      bus_byte("rst_lw.b1", 16'h0401, 1'b0, 8'h00, 8'hBB, 0);
      check("rst_lw.req_before", 32'(mem_req_o), 32'h1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_async");
      @(negedge clk);
      check_reset_outputs("rst_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_release");
      send("lb2", 6'h25, 32'h0000_0010, 32'h0);
      bus_byte("lb2.b0", 16'h0010, 1'b0, 8'h00, 8'h7F, 0);
      retire("lb2", 32'h0000007F, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
